fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch sequencer that is the next generation of the CPU's fetch path. It owns the program counter and an internal return-address stack (RAS), and drives a ROM with configurable read latency. It presents each instruction to the decoder over a valid/ready handshake. Jump, call and return are resolved at the accept point, and RAS overflow, underflow and conflicting controls put the block into a halted fault state.

Parameters:
PC_W, 8, program counter and ROM address width
INSTR_W, 24, instruction width (3 bytes)
RAS_DEPTH, 8, return-stack entries (power of 2, ≥2)
ROM_LAT, 1, ROM read latency in cycles (1..3)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock; everything updates on the rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  allow new fetches; sampled only at instruction boundaries
rom_addr  out  PC_W  ROM address, always equal to pc
rom_rdata  in  INSTR_W  ROM data, valid ROM_LAT cycles after rom_addr is stable
instr_valid  out  1  instr_data and instr_pc hold a valid instruction
instr_ready  in  1  decoder accepts the instruction
instr_data  out  INSTR_W  registered instruction
instr_pc  out  PC_W  address of instr_data
jump_en  in  1  on accept: pc <= target
call_en  in  1  on accept: push instr_pc+1, then pc <= target
ret_en  in  1  on accept: pc <= popped RAS top
target  in  PC_W  jump/call destination
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
halted  out  1  fault state active
fault  out  2  00 none, 01 RAS overflow, 10 RAS underflow, 11 control conflict

Behaviour:
- Reset values:
  - pc = RESET_PC, state = S_IDLE, instr_valid = 0, instr_data = 0.
  - RAS count = 0, ras_empty = 1, ras_full = 0.
  - halted = 0, fault = 00.
- Reset mid-operation: any in-flight fetch is discarded and RAS contents are dropped.
- FSM states: S_IDLE, S_WAIT, S_VALID, S_HALT.
- S_IDLE: stays while enable = 0. With enable = 1, goes to S_WAIT and clears wait_cnt.
- S_WAIT:
  - wait_cnt increments each cycle while rom_addr is held constant.
  - On the edge ending the cycle where wait_cnt == ROM_LAT: instr_data <= rom_rdata, instr_pc <= pc, then go to S_VALID.
  - Fetch-start to instr_valid latency is ROM_LAT+1 cycles.
  - enable dropping during S_WAIT does not abort the fetch.
- S_VALID:
  - instr_valid = 1.
  - instr_data and instr_pc stay stable until instr_ready = 1 (no combinational path from instr_ready to data).
- Accept (S_VALID with instr_ready = 1): jump_en, call_en, ret_en and target are sampled in this cycle only.
  - None asserted: pc <= instr_pc + 1, modulo 2^PC_W (0xFF wraps to 0x00 when PC_W = 8).
  - jump_en only: pc <= target.
  - call_en only, RAS not full: push instr_pc+1 (wrapping), pc <= target.
  - call_en only, RAS full: no push, pc unchanged, fault <= 01, go to S_HALT.
  - ret_en only, RAS not empty: pc <= top, pop.
  - ret_en only, RAS empty: fault <= 10, go to S_HALT.
  - Two or more of the three asserted: fault <= 11, go to S_HALT, RAS unchanged.
  - Non-fault case: next state is S_WAIT if enable = 1, otherwise S_IDLE.
- Control inputs asserted outside an accept cycle are ignored.
- S_HALT:
  - instr_valid = 0, halted = 1, fault held.
  - Exits only via rst.
- RAS behaviour:
  - LIFO.
  - Push and pop never occur in the same cycle (guaranteed by the conflict rule).
  - ras_full and ras_empty are registered and reflect the count after the edge.
- Throughput: one instruction per ROM_LAT+2 cycles when instr_ready is held at 1.

Decomposition:
- Shared package fetch_pkg holds:
  - the state encoding (S_IDLE, S_WAIT, S_VALID, S_HALT);
  - fault codes (FAULT_NONE, FAULT_OVF, FAULT_UNF, FAULT_CONFLICT).
- Sub-module return_stack (params DEPTH, W):
  - inputs: clk, rst, push, push_data, pop;
  - outputs: top, full, empty;
  - contains the pointer/count logic.
- fetch_unit holds the FSM, PC, wait counter and output registers.

Test Plan:
- Sequential fetch: ROM_LAT = 1, ROM word[a] = {a,a,a}, enable = 1, instr_ready = 1 → instr_pc sequence 0,1,2,… with instr_valid every 3rd cycle; first valid 2 cycles after fetch start; pc 0xFF is followed by 0x00.
- Backpressure: hold instr_ready = 0 for 5 cycles while instr_valid = 1 → instr_data/instr_pc unchanged and rom_addr unchanged; accept on cycle 6 → next fetch begins.
- Call/return: RAS_DEPTH = 2; call at pc 0x10 to 0x40, call at 0x40 to 0x80, ret, ret → instr_pc sequence 0x10, 0x40, 0x80, 0x41, 0x11; ras_full = 1 after the second call; ras_empty = 1 at the end.
- Overflow and underflow: third nested call with RAS_DEPTH = 2 → halted = 1, fault = 01, instr_valid = 0 until rst. After reset, ret at pc 0 → fault = 10.
- Conflict and reset: jump_en and ret_en together on accept → fault = 11. Separately, assert rst during S_WAIT → next cycle pc = RESET_PC and instr_valid = 0, and the first fetch afterwards returns word[RESET_PC].

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state and fault encodings for the fetch path
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_OVF      = 2'b01,
    FAULT_UNF      = 2'b10,
    FAULT_CONFLICT = 2'b11
  } fault_t;

  // Conflict outranks the RAS checks: a multi-control accept never touches the stack.
  function automatic fault_t accept_fault(input logic jump, input logic call, input logic ret,
                                          input logic full, input logic empty);
    logic [1:0] n;
    n = {1'b0, jump} + {1'b0, call} + {1'b0, ret};
    if (n > 2'd1)       return FAULT_CONFLICT;
    if (call && full)   return FAULT_OVF;
    if (ret && empty)   return FAULT_UNF;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - ROM, decoder handshake and control/status bundle of the fetch unit
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
);
  logic               enable;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;
  logic               jump_en;
  logic               call_en;
  logic               ret_en;
  logic [PC_W-1:0]    target;
  logic               ras_empty;
  logic               ras_full;
  logic               halted;
  logic [1:0]         fault;

  modport master (
    input  enable, rom_rdata, instr_ready, jump_en, call_en, ret_en, target,
    output rom_addr, instr_valid, instr_data, instr_pc, ras_empty, ras_full, halted, fault
  );

  modport slave (
    output enable, rom_rdata, instr_ready, jump_en, call_en, ret_en, target,
    input  rom_addr, instr_valid, instr_data, instr_pc, ras_empty, ras_full, halted, fault
  );
endinterface

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses with registered full/empty flags
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W:0] count;
  logic [PTR_W:0] count_nxt;
  logic [PTR_W-1:0] top_ptr;

  always_comb begin
    count_nxt = count;
    if (push && !full)
      count_nxt = count + CNT_ONE;
    else if (pop && !empty)
      count_nxt = count - CNT_ONE;
  end

  assign top_ptr = PTR_W'(count - CNT_ONE);
  assign top     = mem[top_ptr];

  // Contents are not cleared on reset; dropping the count discards them.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[count[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencer with ROM latency wait, decoder handshake and return stack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              INSTR_W   = 24,
  parameter int              RAS_DEPTH = 8,
  parameter int              ROM_LAT   = 1,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam logic [1:0] LAT_CNT = 2'(ROM_LAT);

  state_t             state;
  fault_t             fault_q;
  fault_t             acc_fault;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic [PC_W-1:0]    seq_pc;
  logic [PC_W-1:0]    ras_top;
  logic [PC_W-1:0]    instr_pc_q;
  logic [INSTR_W-1:0] instr_data_q;
  logic [1:0]         wait_cnt;
  logic               valid_q;
  logic               halted_q;
  logic               accept;
  logic               push;
  logic               pop;
  logic               ras_full;
  logic               ras_empty;

  assign accept    = (state == S_VALID) && bus.instr_ready;
  assign seq_pc    = instr_pc_q + PC_W'(1);
  assign acc_fault = accept_fault(bus.jump_en, bus.call_en, bus.ret_en, ras_full, ras_empty);
  assign push      = accept && bus.call_en && (acc_fault == FAULT_NONE);
  assign pop       = accept && bus.ret_en  && (acc_fault == FAULT_NONE);

  // Only consulted on a fault-free accept, so at most one control is set here.
  always_comb begin
    next_pc = seq_pc;
    if (bus.jump_en || bus.call_en)
      next_pc = bus.target;
    else if (bus.ret_en)
      next_pc = ras_top;
  end

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (seq_pc),
    .pop       (pop),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      wait_cnt     <= '0;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= FAULT_NONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == LAT_CNT) begin
            instr_data_q <= bus.rom_rdata;
            instr_pc_q   <= pc;
            valid_q      <= 1'b1;
            state        <= S_VALID;
          end
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
            if (acc_fault != FAULT_NONE) begin
              fault_q  <= acc_fault;
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc       <= next_pc;
              wait_cnt <= '0;
              state    <= bus.enable ? S_WAIT : S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.ras_full    = ras_full;
  assign bus.ras_empty   = ras_empty;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a PC/RAS model
module tb_fetch_unit;
  localparam int         PC_W      = 8;
  localparam int         INSTR_W   = 24;
  localparam int         RAS_DEPTH = 2;
  localparam int         ROM_LAT   = 1;
  localparam logic [7:0] RESET_PC  = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .RAS_DEPTH (RAS_DEPTH),
    .ROM_LAT   (ROM_LAT),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] rom [256];
  always @(posedge clk) bus.rom_rdata <= rom[bus.rom_addr];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_pc;
  logic [7:0] m_ras [$];
  logic [1:0] last_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.call_en     = 1'b0;
    bus.ret_en      = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 1;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(ROM_LAT + 2));
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr",  32'(bus.rom_addr), 32'(RESET_PC));
    chk("rst_data",  32'(bus.instr_data), 32'd0);
    chk("rst_empty", 32'(bus.ras_empty), 32'd1);
    chk("rst_full",  32'(bus.ras_full), 32'd0);
    chk("rst_halt",  32'(bus.halted), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    m_pc = RESET_PC;
    m_ras.delete();
    tick();
  endtask

  task automatic do_accept(input logic j, input logic c, input logic r,
                           input logic [7:0] t, input int stall);
    logic [1:0] f;
    chk("instr_pc",   32'(bus.instr_pc), 32'(m_pc));
    chk("instr_data", 32'(bus.instr_data), 32'({3{m_pc}}));
    for (int i = 0; i < stall; i++) begin
      bus.jump_en = 1'($urandom);
      bus.call_en = 1'($urandom);
      bus.ret_en  = 1'($urandom);
      bus.target  = 8'($urandom);
      tick();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_pc",    32'(bus.instr_pc), 32'(m_pc));
      chk("stall_data",  32'(bus.instr_data), 32'({3{m_pc}}));
      chk("stall_addr",  32'(bus.rom_addr), 32'(m_pc));
    end
    bus.instr_ready = 1'b1;
    bus.jump_en     = j;
    bus.call_en     = c;
    bus.ret_en      = r;
    bus.target      = t;
    f = 2'd0;
    if (int'(j) + int'(c) + int'(r) > 1)        f = 2'd3;
    else if (c && m_ras.size() == RAS_DEPTH)    f = 2'd1;
    else if (r && m_ras.size() == 0)            f = 2'd2;
    else if (c) begin m_ras.push_back(m_pc + 8'd1); m_pc = t; end
    else if (r) m_pc = m_ras.pop_back();
    else if (j) m_pc = t;
    else        m_pc = m_pc + 8'd1;
    tick();
    clear_ctrl();
    bus.target = 8'($urandom);
    chk("acc_halted", 32'(bus.halted), 32'(f != 2'd0));
    chk("acc_fault",  32'(bus.fault), 32'(f));
    chk("acc_valid",  32'(bus.instr_valid), 32'd0);
    chk("ras_full",   32'(bus.ras_full), 32'(m_ras.size() == RAS_DEPTH));
    chk("ras_empty",  32'(bus.ras_empty), 32'(m_ras.size() == 0));
    if (f == 2'd0) chk("next_addr", 32'(bus.rom_addr), 32'(m_pc));
    last_fault = f;
  endtask

  task automatic halt_hold(input logic [1:0] f);
    for (int i = 0; i < 4; i++) begin
      bus.instr_ready = 1'($urandom);
      bus.jump_en     = 1'($urandom);
      bus.ret_en      = 1'($urandom);
      tick();
      chk("hold_halted", 32'(bus.halted), 32'd1);
      chk("hold_fault",  32'(bus.fault), 32'(f));
      chk("hold_valid",  32'(bus.instr_valid), 32'd0);
    end
    clear_ctrl();
  endtask

  initial begin
    int         k;
    logic       j, c, r;
    for (int a = 0; a < 256; a++) rom[a] = {3{8'(a)}};
    bus.enable = 1'b0;
    bus.target = 8'h00;
    clear_ctrl();
    rst = 1'b1;
    do_reset();
    repeat (3) tick();
    chk("idle_hold", 32'(bus.instr_valid), 32'd0);
    bus.enable = 1'b1;
    tick();
    wait_valid("first_lat");

    // Full sweep through 0xFF -> 0x00, with one 5-cycle backpressure stall.
    for (int i = 0; i < 257; i++) begin
      do_accept(1'b0, 1'b0, 1'b0, 8'h00, (i == 5) ? 5 : 0);
      wait_valid("seq_lat");
    end

    do_accept(1'b0, 1'b0, 1'b0, 8'h00, 0);
    bus.enable = 1'b0;
    wait_valid("wait_no_abort");
    do_accept(1'b0, 1'b0, 1'b0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_after", 32'(bus.instr_valid), 32'd0);
    end
    chk("idle_addr", 32'(bus.rom_addr), 32'(m_pc));
    bus.enable = 1'b1;
    tick();
    wait_valid("restart_lat");

    do_accept(1'b1, 1'b0, 1'b0, 8'h10, 0); wait_valid("jmp_lat");
    do_accept(1'b0, 1'b1, 1'b0, 8'h40, 0); wait_valid("call1_lat");
    do_accept(1'b0, 1'b1, 1'b0, 8'h80, 0); wait_valid("call2_lat");
    chk("nest_full", 32'(bus.ras_full), 32'd1);
    do_accept(1'b0, 1'b0, 1'b1, 8'h00, 1); wait_valid("ret1_lat");
    do_accept(1'b0, 1'b0, 1'b1, 8'h00, 0); wait_valid("ret2_lat");
    chk("ret_pc", 32'(bus.instr_pc), 32'h11);
    chk("ret_empty", 32'(bus.ras_empty), 32'd1);
    do_accept(1'b0, 1'b1, 1'b0, 8'h40, 0); wait_valid("c1_lat");
    do_accept(1'b0, 1'b1, 1'b0, 8'h80, 0); wait_valid("c2_lat");
    do_accept(1'b0, 1'b1, 1'b0, 8'hC0, 0);
    chk("ovf_code", 32'(last_fault), 32'd1);
    halt_hold(2'b01);

    do_reset();
    wait_valid("unf_lat");
    do_accept(1'b0, 1'b0, 1'b1, 8'h00, 0);
    halt_hold(2'b10);

    do_reset();
    wait_valid("cfl_lat");
    do_accept(1'b1, 1'b0, 1'b1, 8'h33, 0);
    halt_hold(2'b11);

    do_reset();
    wait_valid("pre_rst_lat");
    do_accept(1'b0, 1'b1, 1'b0, 8'h20, 0);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_addr",  32'(bus.rom_addr), 32'(RESET_PC));
    chk("midrst_empty", 32'(bus.ras_empty), 32'd1);
    rst = 1'b0;
    m_pc = RESET_PC;
    m_ras.delete();
    tick();
    wait_valid("midrst_lat");
    chk("midrst_pc",   32'(bus.instr_pc), 32'(RESET_PC));
    chk("midrst_data", 32'(bus.instr_data), 32'(rom[RESET_PC]));

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      j = 1'b0; c = 1'b0; r = 1'b0;
      if (k == 4 || k == 5)      j = 1'b1;
      else if (k == 6 || k == 7) c = 1'b1;
      else if (k == 8)           r = 1'b1;
      else if (k == 9) begin
        j = 1'($urandom); c = 1'($urandom); r = ~(j & c);
      end
      do_accept(j, c, r, 8'($urandom), $urandom_range(0, 3));
      if (last_fault != 2'd0) begin
        halt_hold(last_fault);
        do_reset();
      end
      wait_valid("rand_lat");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
